// File: rtl/mux_nto1_stream_pkg.sv
// Shared types and helpers for the N:1 registered stream multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Index width that never collapses to zero bits, so a 1-bit select stays legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_stream_if.sv
// Producer-lane and consumer-side bundle for mux_nto1_stream.
interface mux_nto1_stream_if
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = clog2_min1(N_CH)
);

  mux_mode_e             mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH*W-1:0]     in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [W-1:0]          out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_nto1_stream_rr_arbiter.sv
// Rotate-priority arbiter: first requester at or above ptr, wrapping N-1 -> 0.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int            idx;
  logic [PW-1:0] idx_l;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap keeps the search correct for non-power-of-two N.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_l = PW'(idx);
      if (!found && req[idx_l]) begin
        found        = 1'b1;
        gnt[idx_l]   = 1'b1;
        gnt_idx      = idx_l;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N:1 stream mux, fixed-select or round-robin; output registered, 1-cycle latency.
// Loads when the output slot is empty or being drained; holds the beat while out_ready=0.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input logic              clk,
  input logic              rst,
  mux_nto1_stream_if.slave bus
);

  localparam int SEL_W = clog2_min1(N_CH);

  logic [SEL_W-1:0] rr_ptr;
  logic [N_CH-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;

  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gnt_idx;
  logic             sel_ok;
  logic             load_en;
  logic             xfer;
  logic [W-1:0]     gnt_data;

  logic [W-1:0]     out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_valid_q;

  rr_arbiter #(.N(N_CH), .PW(SEL_W)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign sel_ok  = (int'(bus.sel) < N_CH);
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    if (bus.mode == MODE_RR) begin
      grant   = arb_gnt;
      gnt_idx = arb_idx;
    end else if (sel_ok && bus.in_valid[bus.sel]) begin
      grant[bus.sel] = 1'b1;
      gnt_idx        = bus.sel;
    end
  end

  // Grant is one-hot, so an OR-reduction picks the winning lane without an index multiply.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) gnt_data = gnt_data | bus.in_data[i*W +: W];
    end
  end

  assign bus.in_ready = grant & {N_CH{load_en && !rst}};
  assign xfer         = |bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      if (xfer) begin
        out_data_q  <= gnt_data;
        out_ch_q    <= gnt_idx;
        out_valid_q <= 1'b1;
        if (bus.mode == MODE_RR) begin
          rr_ptr <= (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream (N_CH=4, W=8), hand-computed expectations.
// Checks sample 1 time unit after the rising edge; registered output seen one cycle after handshake.
// Drives out_ready low to exercise hold behaviour; watchdog flags a stalled run.
module tb_mux_nto1_stream;
    import mux_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux_nto1_stream_if #(.N_CH(4), .W(8)) bus ();

    mux_nto1_stream #(.N_CH(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_d;
    logic [1:0] exp_c;

    initial begin
        #100000;
        failures++;
        $error("FAIL timeout: bench did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst           = 1'b1;
        bus.mode      = MODE_FIXED;
        bus.sel       = 2'd0;
        bus.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 4'b0000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_out_ch", bus.out_ch, 2'd0);

        rst = 1'b0;
        #1;
        chk("fix_in_ready_sel0", bus.in_ready, 4'b0001);

        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            tick();
            exp_d = 8'hA0 + 8'(8'h11 * s);
            exp_c = 2'(s);
            chk("fix_sweep_data", bus.out_data, exp_d);
            chk("fix_sweep_ch", bus.out_ch, exp_c);
            chk("fix_sweep_valid", bus.out_valid, 1'b1);
        end

        bus.sel      = 2'd2;
        bus.in_valid = 4'b1011;
        #1;
        chk("fix_invalid_in_ready", bus.in_ready, 4'b0000);
        tick();
        chk("fix_invalid_valid", bus.out_valid, 1'b0);
        chk("fix_invalid_hold_data", bus.out_data, 8'hD3);
        chk("fix_invalid_hold_ch", bus.out_ch, 2'd3);

        bus.mode     = MODE_RR;
        bus.in_valid = 4'hF;
        #1;
        chk("rr_first_in_ready", bus.in_ready, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_c = 2'(k % 4);
            exp_d = 8'hA0 + 8'(8'h11 * (k % 4));
            chk("rr_fair_ch", bus.out_ch, exp_c);
            chk("rr_fair_data", bus.out_data, exp_d);
            chk("rr_fair_valid", bus.out_valid, 1'b1);
        end

        bus.in_valid = 4'b0001;
        tick();
        chk("rr_seed_ch", bus.out_ch, 2'd0);
        chk("rr_seed_data", bus.out_data, 8'hA0);

        bus.in_valid = 4'b1001;
        #1;
        chk("rr_skip_in_ready", bus.in_ready, 4'b1000);
        tick();
        chk("rr_skip_ch0", bus.out_ch, 2'd3);
        chk("rr_skip_data0", bus.out_data, 8'hD3);
        tick();
        chk("rr_wrap_ch1", bus.out_ch, 2'd0);
        chk("rr_wrap_data1", bus.out_data, 8'hA0);
        tick();
        chk("rr_skip_ch2", bus.out_ch, 2'd3);
        chk("rr_skip_data2", bus.out_data, 8'hD3);

        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        #1;
        chk("bp_in_ready_now", bus.in_ready, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", bus.out_data, 8'hD3);
            chk("bp_hold_ch", bus.out_ch, 2'd3);
            chk("bp_hold_valid", bus.out_valid, 1'b1);
            chk("bp_hold_in_ready", bus.in_ready, 4'b0000);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 4'b0001);
        tick();
        chk("bp_release_ch", bus.out_ch, 2'd0);
        chk("bp_release_data", bus.out_data, 8'hA0);
        chk("bp_release_valid", bus.out_valid, 1'b1);

        bus.out_ready = 1'b0;
        tick();
        chk("mid_stall_ch", bus.out_ch, 2'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 4'b0000);
        tick();
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_data", bus.out_data, 8'h00);
        chk("mid_rst_ch", bus.out_ch, 2'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 4'b0001);
        tick();
        chk("post_rst_ch", bus.out_ch, 2'd0);
        chk("post_rst_data", bus.out_data, 8'hA0);
        chk("post_rst_valid", bus.out_valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
